// File: rtl/sdrc_req_pkg.sv
// Shared types and address/length helpers for the SDRAM request splitter.
package sdrc_req_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic logic [3:0] col_width(input logic [1:0] colbits);
        return 4'd8 + {2'b00, colbits};
    endfunction

    function automatic logic [1:0] len_shift(input logic [1:0] width);
        case (width)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd2;
        endcase
    endfunction

    // Words left before the column field rolls over into the next bank/row.
    function automatic logic [12:0] page_room(input logic [12:0] addr_lo, input logic [3:0] cw);
        logic [12:0] size;
        size = 13'd1 << cw;
        return size - (addr_lo & (size - 13'd1));
    endfunction

endpackage

// File: rtl/sdrc_rr_arb.sv
// Round-robin arbiter: one-hot grant, last winner drops to lowest priority.
module sdrc_rr_arb #(
    parameter int NCH  = 2,
    parameter int CH_W = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NCH-1:0]  req,
    input  logic            en,
    output logic [NCH-1:0]  grant,
    output logic [CH_W-1:0] win
);

    logic [CH_W-1:0] ptr;
    logic            found;
    int unsigned     idx;

    always_comb begin
        grant = '0;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < NCH; i++) begin
            idx = (32'(ptr) + i) % NCH;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = CH_W'(idx);
            end
        end
        if (en && found) grant[win] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (|grant) begin
            ptr <= (32'(win) == NCH - 1) ? '0 : win + 1'b1;
        end
    end

endmodule

// File: rtl/sdrc_req_split.sv
// Multi-channel SDRAM request generator: arbitrates, scales length to SDRAM width,
// and splits each request into page- and max-chunk-bounded bank-controller chunks.
module sdrc_req_split
    import sdrc_req_pkg::*;
#(
    parameter int NCH    = 2,
    parameter int APP_AW = 26,
    parameter int APP_RW = 9,
    parameter int REQ_BW = 12,
    parameter int ID_W   = 4,
    parameter int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            cfg_colbits,
    input  logic [1:0]            sdr_width,
    input  logic [REQ_BW-1:0]     cfg_max_chunk,
    input  logic [NCH-1:0]        req,
    input  logic [NCH*ID_W-1:0]   req_id,
    input  logic [NCH*APP_AW-1:0] req_addr,
    input  logic [NCH*APP_RW-1:0] req_len,
    input  logic [NCH-1:0]        req_wr_n,
    input  logic [NCH-1:0]        req_wrap,
    output logic [NCH-1:0]        req_ack,
    output logic                  r2x_idle,
    output logic                  r2b_req,
    output logic [ID_W-1:0]       r2b_req_id,
    output logic [CH_W-1:0]       r2b_ch,
    output logic                  r2b_start,
    output logic                  r2b_last,
    output logic                  r2b_wrap,
    output logic                  r2b_write,
    output logic [1:0]            r2b_ba,
    output logic [12:0]           r2b_raddr,
    output logic [12:0]           r2b_caddr,
    output logic [REQ_BW-1:0]     r2b_len,
    input  logic                  b2r_ack,
    input  logic                  b2r_arb_ok
);

    state_t              state, state_nxt;
    logic [NCH-1:0]      grant;
    logic [CH_W-1:0]     win;
    logic                take;

    logic [APP_AW-1:0]   addr_q, addr_n;
    logic [REQ_BW-1:0]   rem_q, rem_n;
    logic [3:0]          cw_q, cw_n;
    logic [REQ_BW-1:0]   max_q, max_n;
    logic                wrap_n;
    logic                load, start_n;

    logic [12:0]         room;
    logic [REQ_BW-1:0]   clen;
    logic [39:0]         ext;
    logic [1:0]          ba_n;
    logic [12:0]         raddr_n, caddr_n;

    sdrc_rr_arb #(
        .NCH  (NCH),
        .CH_W (CH_W)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .en    ((state == IDLE) && b2r_arb_ok),
        .grant (grant),
        .win   (win)
    );

    assign take     = |grant;
    assign req_ack  = grant;
    assign r2x_idle = (state == IDLE) && ~|req;

    always_comb begin
        state_nxt = state;
        addr_n    = addr_q;
        rem_n     = rem_q;
        cw_n      = cw_q;
        max_n     = max_q;
        wrap_n    = r2b_wrap;
        load      = 1'b0;
        start_n   = 1'b0;
        case (state)
            IDLE: begin
                if (take) begin
                    addr_n    = req_addr[int'(win)*APP_AW +: APP_AW];
                    rem_n     = REQ_BW'(req_len[int'(win)*APP_RW +: APP_RW]) << len_shift(sdr_width);
                    cw_n      = col_width(cfg_colbits);
                    max_n     = cfg_max_chunk;
                    wrap_n    = req_wrap[win];
                    load      = 1'b1;
                    start_n   = 1'b1;
                    state_nxt = (rem_n == '0) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                if (b2r_ack) begin
                    addr_n    = addr_q + APP_AW'(r2b_len);
                    rem_n     = rem_q - r2b_len;
                    load      = (rem_n != '0);
                    state_nxt = (rem_n != '0) ? ISSUE : IDLE;
                end
            end
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Chunk fields are derived from the post-update address/length so they register in one step.
    always_comb begin
        room = page_room(addr_n[12:0], cw_n);
        clen = rem_n;
        if (!wrap_n) begin
            if (32'(room) < 32'(clen)) clen = REQ_BW'(room);
            if (max_n != '0 && max_n < clen) clen = max_n;
        end
        ext     = 40'(addr_n);
        caddr_n = 13'(ext & ((40'd1 << cw_n) - 40'd1));
        ba_n    = 2'(ext >> cw_n);
        raddr_n = 13'(ext >> (cw_n + 4'd2));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            cw_q       <= '0;
            max_q      <= '0;
            r2b_req    <= 1'b0;
            r2b_req_id <= '0;
            r2b_ch     <= '0;
            r2b_start  <= 1'b0;
            r2b_last   <= 1'b0;
            r2b_wrap   <= 1'b0;
            r2b_write  <= 1'b0;
            r2b_ba     <= '0;
            r2b_raddr  <= '0;
            r2b_caddr  <= '0;
            r2b_len    <= '0;
        end else begin
            state   <= state_nxt;
            addr_q  <= addr_n;
            rem_q   <= rem_n;
            cw_q    <= cw_n;
            max_q   <= max_n;
            r2b_req <= (state_nxt == ISSUE);
            if (take) begin
                r2b_req_id <= req_id[int'(win)*ID_W +: ID_W];
                r2b_ch     <= win;
                r2b_wrap   <= req_wrap[win];
                r2b_write  <= ~req_wr_n[win];
            end
            if (load) begin
                r2b_start <= start_n;
                r2b_last  <= (clen == rem_n);
                r2b_len   <= clen;
                r2b_ba    <= ba_n;
                r2b_raddr <= raddr_n;
                r2b_caddr <= caddr_n;
            end
        end
    end

endmodule

// File: tb/tb_sdrc_req_split.sv
// Randomized bench for sdrc_req_split against a chunk-list model built from plain arithmetic.
module tb_sdrc_req_split;

    localparam int NCH = 2, APP_AW = 26, APP_RW = 9, REQ_BW = 12, ID_W = 4, CH_W = 1;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [1:0]            cfg_colbits = '0;
    logic [1:0]            sdr_width = '0;
    logic [REQ_BW-1:0]     cfg_max_chunk = '0;
    logic [NCH-1:0]        req = '0;
    logic [NCH*ID_W-1:0]   req_id = '0;
    logic [NCH*APP_AW-1:0] req_addr = '0;
    logic [NCH*APP_RW-1:0] req_len = '0;
    logic [NCH-1:0]        req_wr_n = '0;
    logic [NCH-1:0]        req_wrap = '0;
    logic [NCH-1:0]        req_ack;
    logic                  r2x_idle, r2b_req, r2b_start, r2b_last, r2b_wrap, r2b_write;
    logic [ID_W-1:0]       r2b_req_id;
    logic [CH_W-1:0]       r2b_ch;
    logic [1:0]            r2b_ba;
    logic [12:0]           r2b_raddr, r2b_caddr;
    logic [REQ_BW-1:0]     r2b_len;
    logic                  b2r_ack = 1'b0;
    logic                  b2r_arb_ok = 1'b0;

    sdrc_req_split #(
        .NCH(NCH), .APP_AW(APP_AW), .APP_RW(APP_RW), .REQ_BW(REQ_BW), .ID_W(ID_W), .CH_W(CH_W)
    ) dut (
        .clk(clk), .reset(reset), .cfg_colbits(cfg_colbits), .sdr_width(sdr_width),
        .cfg_max_chunk(cfg_max_chunk), .req(req), .req_id(req_id), .req_addr(req_addr),
        .req_len(req_len), .req_wr_n(req_wr_n), .req_wrap(req_wrap), .req_ack(req_ack),
        .r2x_idle(r2x_idle), .r2b_req(r2b_req), .r2b_req_id(r2b_req_id), .r2b_ch(r2b_ch),
        .r2b_start(r2b_start), .r2b_last(r2b_last), .r2b_wrap(r2b_wrap), .r2b_write(r2b_write),
        .r2b_ba(r2b_ba), .r2b_raddr(r2b_raddr), .r2b_caddr(r2b_caddr), .r2b_len(r2b_len),
        .b2r_ack(b2r_ack), .b2r_arb_ok(b2r_arb_ok)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned id, ch, ba, raddr, caddr, len;
        bit start, last, wrap, wr;
    } chunk_t;

    int     checks = 0;
    int     failures = 0;
    chunk_t gq[$];
    chunk_t mq[$];
    bit     m_drain = 0;
    bit     m_fresh = 1;
    int     m_ptr = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Expected chunk list of one request, straight from the splitting rules.
    function automatic void gen(int unsigned addr, int unsigned lenapp, int unsigned sw,
                                int unsigned cb, int unsigned maxc, bit wrap,
                                int unsigned id, int unsigned ch, bit wr);
        int unsigned rem, cw, room, l;
        chunk_t c;
        gq.delete();
        rem = lenapp * ((sw == 0) ? 1 : (sw == 1) ? 2 : 4);
        cw  = 8 + cb;
        while (rem > 0) begin
            room = (1 << cw) - (addr % (1 << cw));
            l = rem;
            if (!wrap) begin
                if (room < l) l = room;
                if (maxc != 0 && maxc < l) l = maxc;
            end
            c.id = id; c.ch = ch; c.wrap = wrap; c.wr = wr;
            c.start = (gq.size() == 0);
            c.last  = (l == rem);
            c.len   = l;
            c.caddr = addr % (1 << cw);
            c.ba    = (addr >> cw) & 3;
            c.raddr = (addr >> (cw + 2)) & 32'h1FFF;
            gq.push_back(c);
            addr = (addr + l) % (1 << APP_AW);
            rem -= l;
        end
    endfunction

    // Per-cycle compare and model advance.
    always @(negedge clk) begin
        logic [NCH-1:0] exp_ack;
        int w;
        bit idle;
        exp_ack = '0;
        w = -1;
        idle = (mq.size() == 0) && !m_drain;
        if (idle && b2r_arb_ok) begin
            for (int i = 0; i < NCH; i++) begin
                int c;
                c = (m_ptr + i) % NCH;
                if (w < 0 && req[c]) w = c;
            end
            if (w >= 0) exp_ack[w] = 1'b1;
        end
        chk("req_ack", 64'(req_ack), 64'(exp_ack));
        chk("r2x_idle", 64'(r2x_idle), 64'(idle && (req == '0)));
        chk("r2b_req", 64'(r2b_req), 64'(mq.size() != 0));
        if (mq.size() != 0 || m_fresh) begin
            chunk_t e;
            if (mq.size() != 0) e = mq[0];
            else e = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
            chk("r2b_len", 64'(r2b_len), 64'(e.len));
            chk("r2b_caddr", 64'(r2b_caddr), 64'(e.caddr));
            chk("r2b_raddr", 64'(r2b_raddr), 64'(e.raddr));
            chk("r2b_ba", 64'(r2b_ba), 64'(e.ba));
            chk("r2b_id", 64'(r2b_req_id), 64'(e.id));
            chk("r2b_ch", 64'(r2b_ch), 64'(e.ch));
            chk("r2b_flags", 64'({r2b_start, r2b_last, r2b_wrap, r2b_write}),
                64'({e.start, e.last, e.wrap, e.wr}));
        end
        if (reset) begin
            mq.delete();
            m_drain = 0;
            m_ptr = 0;
            m_fresh = 1;
        end else if (mq.size() != 0) begin
            if (b2r_ack) void'(mq.pop_front());
        end else if (m_drain) begin
            m_drain = 0;
        end else if (w >= 0) begin
            gen(req_addr[w*APP_AW +: APP_AW], req_len[w*APP_RW +: APP_RW], sdr_width,
                cfg_colbits, cfg_max_chunk, req_wrap[w], req_id[w*ID_W +: ID_W], w, !req_wr_n[w]);
            foreach (gq[k]) mq.push_back(gq[k]);
            if (gq.size() == 0) m_drain = 1;
            m_ptr = (w + 1) % NCH;
            m_fresh = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(int c, int unsigned id, int unsigned addr, int unsigned len, bit wr_n, bit wrap);
        req_id[c*ID_W +: ID_W]       = ID_W'(id);
        req_addr[c*APP_AW +: APP_AW] = APP_AW'(addr);
        req_len[c*APP_RW +: APP_RW]  = APP_RW'(len);
        req_wr_n[c] = wr_n;
        req_wrap[c] = wrap;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        // Hand-worked expectations pinning the model.
        gen(32'h0F0, 16, 1, 0, 0, 0, 3, 0, 1);
        chk("pin_split_n", 64'(gq.size()), 64'd2);
        if (gq.size() == 2) begin
            chk("pin_split_c0", {gq[0].len, gq[0].ba, gq[0].caddr, 32'({gq[0].start, gq[0].last})},
                {32'd16, 32'd0, 32'h0F0, 32'b10});
            chk("pin_split_c1", {gq[1].len, gq[1].ba, gq[1].caddr, 32'({gq[1].start, gq[1].last})},
                {32'd16, 32'd1, 32'h000, 32'b01});
        end
        gen(0, 20, 0, 0, 8, 0, 0, 1, 0);
        chk("pin_max_n", 64'(gq.size()), 64'd3);
        if (gq.size() == 3) begin
            chk("pin_max_len", 64'({gq[0].len[7:0], gq[1].len[7:0], gq[2].len[7:0]}), 64'h080804);
            chk("pin_max_col", 64'({gq[0].caddr[7:0], gq[1].caddr[7:0], gq[2].caddr[7:0]}), 64'h000810);
            chk("pin_max_last", 64'({gq[0].last, gq[1].last, gq[2].last}), 64'b001);
        end
        gen(32'h0FE, 4, 0, 0, 0, 1, 0, 0, 0);
        chk("pin_wrap_n", 64'(gq.size()), 64'd1);
        if (gq.size() == 1)
            chk("pin_wrap_c", {gq[0].len, gq[0].caddr, 32'({gq[0].start, gq[0].last, gq[0].wrap})},
                {32'd4, 32'h0FE, 32'b111});

        do_reset();
        @(negedge clk);
        chk("rst_outs", 64'({r2b_req, r2b_len, r2b_caddr, req_ack, r2x_idle}), 64'({1'b0, 12'd0, 13'd0, 2'b00, 1'b1}));

        // Page split with backpressure
        step();
        b2r_arb_ok = 1'b1;
        sdr_width = 2'b01; cfg_colbits = 2'b00; cfg_max_chunk = '0;
        set_ch(0, 5, 32'h0F0, 16, 0, 0);
        req = 2'b01;
        @(negedge clk);
        chk("split_ack", 64'(req_ack), 64'b01);
        step();
        req = '0;
        sdr_width = 2'b10; cfg_colbits = 2'b11;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_caddr", 64'({r2b_req, r2b_caddr}), 64'({1'b1, 13'h0F0}));
            step();
        end
        b2r_ack = 1'b1;
        step();
        @(negedge clk);
        chk("split_c1", 64'({r2b_ba, r2b_caddr, r2b_len}), 64'({2'd1, 13'h000, 12'd16}));
        step();

        // Max chunk on ch1
        sdr_width = 2'b00; cfg_colbits = 2'b00; cfg_max_chunk = 12'd8;
        set_ch(1, 9, 0, 20, 1, 0);
        req = 2'b10;
        step();
        req = '0;
        repeat (5) step();

        // Wrap
        set_ch(0, 2, 32'h0FE, 4, 0, 1);
        cfg_max_chunk = '0;
        req = 2'b01;
        step();
        req = '0;
        @(negedge clk);
        chk("wrap_c", 64'({r2b_req, r2b_wrap, r2b_start, r2b_last, r2b_len, r2b_caddr}),
            64'({4'b1111, 12'd4, 13'h0FE}));
        repeat (3) step();

        // Fairness
        do_reset();
        set_ch(0, 1, 32'h100, 1, 1, 0);
        set_ch(1, 2, 32'h200, 1, 1, 0);
        req = 2'b11; b2r_ack = 1'b1; b2r_arb_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("fair_ack", 64'(req_ack), (i % 2 == 0) ? 64'b01 : 64'b10);
            step();
            @(negedge clk);
            chk("fair_ch", 64'({r2b_req, r2b_ch}), (i % 2 == 0) ? 64'b10 : 64'b11);
            step();
        end

        // Arbitration gating
        b2r_arb_ok = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("arb_gate", 64'(req_ack), 64'd0);
            step();
        end

        // Zero-length request
        req = 2'b00;
        step();
        b2r_arb_ok = 1'b1;
        set_ch(0, 7, 32'h40, 0, 0, 0);
        req = 2'b01;
        @(negedge clk);
        chk("zero_ack", 64'(req_ack), 64'b01);
        step();
        req = '0;
        @(negedge clk);
        chk("zero_noreq", 64'({r2b_req, r2x_idle}), 64'b00);
        step();
        @(negedge clk);
        chk("zero_idle", 64'({r2b_req, r2x_idle}), 64'b01);

        // Reset mid-split
        do_reset();
        sdr_width = 2'b00; cfg_max_chunk = 12'd8;
        set_ch(0, 4, 0, 20, 0, 0);
        req = 2'b01; b2r_ack = 1'b0;
        step();
        req = '0;
        @(negedge clk);
        chk("mid_c0", 64'({r2b_req, r2b_len}), 64'({1'b1, 12'd8}));
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_ch(1, 3, 32'h10, 2, 0, 0);
        req = 2'b11;
        @(negedge clk);
        chk("mid_rst", 64'({r2b_req, r2b_len, r2b_caddr, r2b_start}), 64'd0);
        chk("mid_ptr", 64'(req_ack), 64'b01);
        step();

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            req        = NCH'($urandom);
            b2r_ack    = ($urandom % 4) != 0;
            b2r_arb_ok = ($urandom % 8) != 0;
            reset      = ($urandom % 600) == 0;
            cfg_colbits = 2'($urandom);
            sdr_width   = 2'($urandom);
            case ($urandom % 5)
                0: cfg_max_chunk = '0;
                1: cfg_max_chunk = 12'd4;
                2: cfg_max_chunk = 12'd13;
                3: cfg_max_chunk = 12'd100;
                default: cfg_max_chunk = 12'($urandom_range(1, 64));
            endcase
            for (int c = 0; c < NCH; c++) begin
                int unsigned a, l;
                a = $urandom;
                if ($urandom % 2 == 0) a = (a & ~32'h7FF) | 32'h7F0 | ($urandom % 16);
                l = ($urandom % 6 == 0) ? 0 : ($urandom % 10 == 0) ? $urandom_range(1, 511) : $urandom_range(1, 40);
                set_ch(c, $urandom, a, l, 1'($urandom), ($urandom % 8) == 0);
            end
            step();
        end
        reset = 1'b0;
        step();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdrc_req_split.md
# sdrc_req_split

Multi-channel successor to the SDRAM request generator. It arbitrates round-robin among `NCH` application request ports and scales each request length to the configured SDRAM width. It then splits the request into as many bank-controller chunks as page boundaries and a programmable maximum chunk length require, and presents each chunk to the bank controller with its bank, row and column already decoded. It sits between the application port mux and the bank controller.

## Interface
- `NCH`, 2: number of application request channels (≥1).
- `APP_AW`, 26: application address width.
- `APP_RW`, 9: application request length width.
- `REQ_BW`, 12: chunk length width; must be ≥ `APP_RW`+2.
- `ID_W`, 4: request ID width.
- `CH_W`, `$clog2(NCH)` (min 1): channel index width.

Ports:
- `clk`  in  1  single clock; all logic rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `cfg_colbits`  in  2  column bits: 00=8, 01=9, 10=10, 11=11.
- `sdr_width`  in  2  SDRAM width: 00=32b, 01=16b, 1x=8b.
- `cfg_max_chunk`  in  `REQ_BW`  maximum chunk length; 0 means unlimited.
- `req`  in  `NCH`  per-channel request.
- `req_id`  in  `NCH*ID_W`  per-channel ID, packed with ch0 in the LSBs.
- `req_addr`  in  `NCH*APP_AW`  per-channel address.
- `req_len`  in  `NCH*APP_RW`  per-channel length in application words.
- `req_wr_n`  in  `NCH`  0=write, 1=read.
- `req_wrap`  in  `NCH`  1=wrap within the page; the request is never split.
- `req_ack`  out  `NCH`  one-hot acceptance pulse.
- `r2x_idle`  out  1  IDLE state and no `req` bit set.
- `r2b_req`  out  1  chunk valid.
- `r2b_req_id`, `r2b_ch`  out  `ID_W`, `CH_W`  ID and source channel of the chunk.
- `r2b_start`, `r2b_last`  out  1  first and last chunk of the request.
- `r2b_wrap`, `r2b_write`  out  1  wrap mode; 1=write.
- `r2b_ba`, `r2b_raddr`, `r2b_caddr`  out  2, 13, 13  bank, row, column.
- `r2b_len`  out  `REQ_BW`  chunk length in SDRAM words.
- `b2r_ack`  in  1  chunk accepted.
- `b2r_arb_ok`  in  1  bank controller can take a new request.

## Operation
- **States:** IDLE, ISSUE, DRAIN.
- **IDLE:**
  - If any `req` bit is set and `b2r_arb_ok`=1, the round-robin winner gets a combinational `req_ack` that cycle. Its fields are latched, and the state moves to ISSUE, or to DRAIN if the length is 0.
  - Round-robin: the channel granted last has the lowest priority next time. The pointer resets to 0, so ch0 has highest priority after reset.
- **Length scaling:** `len_int = req_len << s`, where s = 0, 1 or 2 for `sdr_width` 00, 01 and 1x.
- **Column width:** cw = 8 + `cfg_colbits`.
- **Chunk length** is the minimum of:
  - the remaining length;
  - page room, 2^cw − addr[cw−1:0];
  - `cfg_max_chunk`, when nonzero.
  - If wrap=1, the chunk length is the full remaining length and the request is issued as a single chunk.
- **Address decode** of the current chunk address:
  - caddr = zero-extended addr[cw−1:0];
  - ba = addr[cw+1:cw];
  - raddr = addr[cw+14:cw+2]; address bits beyond `APP_AW` read as 0.
- **ISSUE:**
  - `r2b_req`=1. On `b2r_ack`: remaining −= len and addr += len, with the address wrapping modulo 2^`APP_AW`.
  - Stay in ISSUE if remaining ≠ 0; otherwise go to IDLE.
- **Flags:** `r2b_start`=1 only on the first chunk. `r2b_last`=1 when chunk len equals remaining.
- **DRAIN:** a zero-length request is acknowledged but no chunk is issued; return to IDLE next cycle.
- **Reset mid-operation:** the next cycle is IDLE with `r2b_req`=0; outstanding chunks are discarded.

## Timing
- **Reset values:**
  - `r2b_req`, `r2b_start`, `r2b_last`, `r2b_wrap`, `r2b_write` = 0.
  - `r2b_req_id`, `r2b_ch`, `r2b_ba`, `r2b_raddr`, `r2b_caddr`, `r2b_len` = 0.
  - `req_ack` = 0; `r2x_idle` = ~|`req`.
- **Latency:**
  - `req_ack` in cycle T → `r2b_req` and the first chunk fields registered and valid at T+1.
  - `b2r_ack` at cycle T with more data remaining → next chunk fields valid at T+1 with `r2b_req` held high (no bubble).
- **Stability:** all `r2b_*` outputs are stable while `r2b_req`=1 and `b2r_ack`=0.
- **Back-to-back requests:** after the final `b2r_ack`, IDLE is entered, so the earliest next `req_ack` is 1 cycle later.
- **Config inputs:** `cfg_*` and `sdr_width` are sampled at `req_ack` only. Changes during ISSUE have no effect on the request in flight.

## Structure
- **Package `sdrc_req_pkg`:** state enum; functions `col_width(cfg_colbits)`, `len_shift(sdr_width)` and `page_room(addr, cw)`.
- **Sub-module `sdrc_rr_arb`:** parametrised `NCH` round-robin arbiter with one-hot grant, pointer update on grant, and synchronous active-high reset.
- Chunk length, address decode and the FSM live in the top module; the chunk fields are registered from the next-state address and length.

## Test plan
- **Page split (16-bit):** `sdr_width`=01, colbits=00, addr=0x0F0, len=16 → two chunks.
  - Chunk 1: len 16, ba0, caddr 0xF0, start=1, last=0.
  - Chunk 2: len 16, ba1, caddr 0x00, start=0, last=1.
- **Max chunk:** `sdr_width`=00, `cfg_max_chunk`=8, addr=0, len=20 → chunks of 8, 8, 4 at caddr 0, 8, 16; last only on the third.
- **Wrap:** `req_wrap`=1, colbits=00, addr=0xFE, len=4 → one chunk, len 4, caddr 0xFE, `r2b_wrap`=1, start=last=1.
- **Fairness:** NCH=2, both `req` held high, `b2r_ack` immediate → `req_ack` alternates ch0, ch1, ch0…, with `r2b_ch` matching each grant.
- **Backpressure and gating:**
  - `b2r_ack` held low 10 cycles → `r2b_*` stable throughout.
  - `b2r_arb_ok`=0 → no `req_ack`.
  - len=0 → `req_ack` pulse, no `r2b_req`.
- **Reset mid-split:** assert `reset` during chunk 1 of a 3-chunk request → `r2b_req`=0 the next cycle, all outputs at reset values, and the arbitration pointer back to ch0.
